// File: rtl/bank_sram_butterfly_read_if_pkg.sv
// Shared types, sizing constants and the butterfly select helper for the bank SRAM read path.
// BANK_SRAM_BF_READ_PIPE_EN selects the split, pipelined butterfly (latency 3, credit depth 3).
package bank_sram_butterfly_read_if_pkg;

    localparam int BW     = 8;
    localparam int NDATA  = 32;
    localparam int NBANK  = 16;
    localparam int XOR_BW = 4;

    localparam int CLOG2_NDATA  = $clog2(NDATA);
    localparam int CLOG2_NBANK  = $clog2(NBANK);
    localparam int CLOG2_XOR_BW = $clog2(XOR_BW);

    typedef logic [BW-1:0]            bank_word_t;
    typedef bank_word_t [NBANK-1:0]   bank_row_t;
    typedef logic [CLOG2_NBANK-1:0]   bf_sel_t;
    typedef logic [CLOG2_NDATA-1:0]   hiaddr_t;
    typedef logic [CLOG2_XOR_BW-1:0]  scheme_idx_t;
    typedef scheme_idx_t [CLOG2_NBANK-1:0] xor_scheme_t;

`ifdef BANK_SRAM_BF_READ_PIPE_EN
    localparam int READ_LATENCY = 3;
    localparam int CREDIT_DEPTH = 3;
`else
    localparam int READ_LATENCY = 2;
    localparam int CREDIT_DEPTH = 2;
`endif

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = 2;

    // Stage i swaps when its mask bit is set and the chosen hiaddr bit is 1.
    function automatic bf_sel_t bf_select(input hiaddr_t     hiaddr,
                                          input xor_scheme_t scheme,
                                          input bf_sel_t     mask);
        bf_sel_t sel;
        sel = '0;
        for (int i = 0; i < CLOG2_NBANK; i++) begin
            sel[i] = mask[i] & hiaddr[scheme[i]];
        end
        return sel;
    endfunction

endpackage

// File: rtl/bank_sram_butterfly_net.sv
// Purely combinational masked XOR butterfly over stages FIRST_STAGE..LAST_STAGE.
// Self-inverse: running the same select twice restores the original lane order.
module bank_sram_butterfly_net #(
    parameter int BW          = 8,
    parameter int NBANK       = 16,
    parameter int FIRST_STAGE = 0,
    parameter int LAST_STAGE  = $clog2(NBANK) - 1
) (
    input  logic [NBANK-1:0][BW-1:0]            data_i,
    input  logic [LAST_STAGE-FIRST_STAGE:0]     sel_i,
    output logic [NBANK-1:0][BW-1:0]            data_o
);

    localparam int NSTAGE = LAST_STAGE - FIRST_STAGE + 1;

    logic [NSTAGE:0][NBANK-1:0][BW-1:0] stage_data;

    assign stage_data[0] = data_i;

    // Stage s pairs lane j with lane j ^ (1 << (FIRST_STAGE + s)).
    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        localparam int DIST = 1 << (FIRST_STAGE + s);
        for (genvar j = 0; j < NBANK; j++) begin : g_lane
            assign stage_data[s+1][j] = sel_i[s] ? stage_data[s][j ^ DIST] : stage_data[s][j];
        end
    end

    assign data_o = stage_data[NSTAGE];

endmodule

// File: rtl/bank_sram_butterfly_read_if.sv
// Bank SRAM read interface: issues a row read, un-swizzles the returned banks and buffers them.
// Define BANK_SRAM_BF_READ_PIPE_EN to register the butterfly halfway (latency 3).
module bank_sram_butterfly_read_if
    import bank_sram_butterfly_read_if_pkg::*;
(
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_rdy,
    output logic                                    o_ack,
    input  logic [CLOG2_NBANK-1:0]                  i_xor_mask,
    input  logic [CLOG2_NBANK-1:0][CLOG2_XOR_BW-1:0] i_xor_scheme,
    input  logic [CLOG2_NDATA-1:0]                  i_hiaddr,
    output logic                                    o_sram_re,
    output logic [CLOG2_NDATA-1:0]                  o_sram_addr,
    input  logic [NBANK-1:0][BW-1:0]                i_sram_data,
    output logic                                    o_rdy,
    input  logic                                    i_ack,
    output logic [NBANK-1:0][BW-1:0]                o_data
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CREDIT_DEPTH);

    logic             accept;
    logic             push;
    logic             pop;
    bank_row_t        push_data;
    logic [CNT_W-1:0] inflight;

    logic             s1_valid_q;
    bf_sel_t          s1_sel_q;

    bank_row_t        fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic [CNT_W-1:0] fifo_cnt_d;

    assign o_rdy  = (fifo_cnt_q != '0);
    assign pop    = o_rdy && i_ack;
    // A full credit pool still accepts when the head leaves this same cycle.
    assign accept = i_rdy && !i_rst && ((inflight < DEPTH_C) || pop);

    assign o_ack       = accept;
    assign o_sram_re   = accept;
    assign o_sram_addr = i_hiaddr;
    assign o_data      = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sel_q <= bf_select(i_hiaddr, i_xor_scheme, i_xor_mask);
            end
        end
    end

`ifdef BANK_SRAM_BF_READ_PIPE_EN
    localparam int SPLIT = CLOG2_NBANK / 2;
    localparam logic [CNT_W-1:0] FIFO_FULL_C = CNT_W'(FIFO_DEPTH);

    bank_row_t                     half_data;
    bank_row_t                     s2_data_q;
    logic [CLOG2_NBANK-SPLIT-1:0]  s2_sel_q;
    logic                          s2_valid_q;
    logic                          s2_advance;
    logic                          fifo_full;

    bank_sram_butterfly_net #(
        .BW          (BW),
        .NBANK       (NBANK),
        .FIRST_STAGE (0),
        .LAST_STAGE  (SPLIT - 1)
    ) u_net_lo (
        .data_i (i_sram_data),
        .sel_i  (s1_sel_q[SPLIT-1:0]),
        .data_o (half_data)
    );

    bank_sram_butterfly_net #(
        .BW          (BW),
        .NBANK       (NBANK),
        .FIRST_STAGE (SPLIT),
        .LAST_STAGE  (CLOG2_NBANK - 1)
    ) u_net_hi (
        .data_i (s2_data_q),
        .sel_i  (s2_sel_q),
        .data_o (push_data)
    );

    // With only two FIFO slots, stage 2 may have to wait on a full FIFO; the credit
    // limit guarantees stage 1 is empty whenever that happens, so no return is lost.
    assign fifo_full  = (fifo_cnt_q == FIFO_FULL_C);
    assign s2_advance = !s2_valid_q || !fifo_full || pop;
    assign push       = s2_valid_q && s2_advance;
    assign inflight   = CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q) + fifo_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sel_q   <= '0;
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= half_data;
            s2_sel_q   <= s1_sel_q[CLOG2_NBANK-1:SPLIT];
        end
    end
`else
    bank_sram_butterfly_net #(
        .BW          (BW),
        .NBANK       (NBANK),
        .FIRST_STAGE (0),
        .LAST_STAGE  (CLOG2_NBANK - 1)
    ) u_net (
        .data_i (i_sram_data),
        .sel_i  (s1_sel_q),
        .data_o (push_data)
    );

    assign push     = s1_valid_q;
    assign inflight = CNT_W'(s1_valid_q) + fifo_cnt_q;
`endif

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // No bypass: a row pushed into an empty FIFO is visible on the following cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule
